// File: rtl/column_strobe_gen.sv
// Per-column configuration strobe sequencer: decodes frame-address writes and
// emits a registered one-hot FrameStrobe pulse framed by setup and hold cycles.
module column_strobe_gen #(
    parameter int MaxFramesPerCol  = 20,
    parameter int FrameSelectWidth = 5,
    parameter int ColSelectWidth   = 5,
    parameter int ColIndex         = 0,
    parameter int StrobeCycles     = 1
) (
    input  logic                                       UserCLK,
    input  logic                                       Reset,
    input  logic [ColSelectWidth+FrameSelectWidth-1:0] FrameAddr,
    input  logic                                       FrameAddr_valid,
    output logic                                       FrameAddr_ready,
    output logic [MaxFramesPerCol-1:0]                 FrameStrobe,
    output logic                                       Busy,
    output logic                                       ErrOutOfRange,
    output logic [15:0]                                FrameCount
);

    localparam int AW = ColSelectWidth + FrameSelectWidth;
    localparam int FW = FrameSelectWidth;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_STROBE = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    localparam logic [ColSelectWidth-1:0] MY_COL   = ColSelectWidth'(ColIndex);
    localparam logic [FW:0]               MAX_IDX  = (FW+1)'(MaxFramesPerCol);
    localparam logic [3:0]                CNT_LOAD = 4'(StrobeCycles - 1);
    localparam logic [15:0]               CNT_MAX  = 16'hFFFF;

    logic [1:0]                 state_q,  state_d;
    logic [FW-1:0]              idx_q,    idx_d;
    logic [3:0]                 cnt_q,    cnt_d;
    logic [MaxFramesPerCol-1:0] strobe_q, strobe_d;
    logic [15:0]                count_q,  count_d;
    logic                       err_q,    err_d;
    logic                       ready_q,  ready_d;
    logic                       busy_q,   busy_d;

    logic [ColSelectWidth-1:0]  req_col_s;
    logic [FW-1:0]              req_idx_s;
    logic                       accept_s;

    function automatic logic [MaxFramesPerCol-1:0] onehot(input logic [FW-1:0] i);
        logic [MaxFramesPerCol-1:0] r;
        r = '0;
        for (int j = 0; j < MaxFramesPerCol; j++) begin
            r[j] = (FW'(j) == i);
        end
        return r;
    endfunction

    assign req_col_s = FrameAddr[AW-1:FW];
    assign req_idx_s = FrameAddr[FW-1:0];
    assign accept_s  = FrameAddr_valid & ready_q;

    // Next-state, strobe and bookkeeping logic
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        strobe_d = '0;
        count_d  = count_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && (req_col_s == MY_COL)) begin
                    if ({1'b0, req_idx_s} >= MAX_IDX) begin
                        err_d = 1'b1;
                    end else begin
                        idx_d   = req_idx_s;
                        state_d = ST_SETUP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                // Strobe flop is loaded here so the pulse appears on the STROBE cycle
                cnt_d    = CNT_LOAD;
                strobe_d = onehot(idx_q);
                state_d  = ST_STROBE;
            end
            ST_STROBE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_HOLD;
                    if (count_q != CNT_MAX) begin
                        count_d = count_q + 16'd1;
                    end else begin
                        count_d = count_q;
                    end
                end else begin
                    cnt_d    = cnt_q - 4'd1;
                    strobe_d = onehot(idx_q);
                end
            end
            ST_HOLD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge UserCLK) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            cnt_q    <= 4'd0;
            strobe_q <= '0;
            count_q  <= 16'd0;
            err_q    <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            strobe_q <= strobe_d;
            count_q  <= count_d;
            err_q    <= err_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    assign FrameAddr_ready = ready_q;
    assign Busy            = busy_q;
    assign FrameStrobe     = strobe_q;
    assign ErrOutOfRange   = err_q;
    assign FrameCount      = count_q;

endmodule

// File: tb/tb_column_strobe_gen.sv
// Directed bench for column_strobe_gen: a per-cycle vector table on a
// StrobeCycles=1 instance plus hand sequences on a StrobeCycles=4 instance.
module tb_column_strobe_gen;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 1: ColIndex=3, StrobeCycles=1
    logic        rst1 = 1'b1, valid1 = 1'b0, ready1, busy1, err1;
    logic [9:0]  addr1 = 10'd0;
    logic [19:0] strobe1;
    logic [15:0] cnt1;

    // Instance 4: ColIndex=3, StrobeCycles=4
    logic        rst4 = 1'b1, valid4 = 1'b0, ready4, busy4, err4;
    logic [9:0]  addr4 = 10'd0;
    logic [19:0] strobe4;
    logic [15:0] cnt4;

    column_strobe_gen #(.MaxFramesPerCol(20), .FrameSelectWidth(5), .ColSelectWidth(5),
                        .ColIndex(3), .StrobeCycles(1)) dut1 (
        .UserCLK(clk), .Reset(rst1), .FrameAddr(addr1), .FrameAddr_valid(valid1),
        .FrameAddr_ready(ready1), .FrameStrobe(strobe1), .Busy(busy1),
        .ErrOutOfRange(err1), .FrameCount(cnt1));

    column_strobe_gen #(.MaxFramesPerCol(20), .FrameSelectWidth(5), .ColSelectWidth(5),
                        .ColIndex(3), .StrobeCycles(4)) dut4 (
        .UserCLK(clk), .Reset(rst4), .FrameAddr(addr4), .FrameAddr_valid(valid4),
        .FrameAddr_ready(ready4), .FrameStrobe(strobe4), .Busy(busy4),
        .ErrOutOfRange(err4), .FrameCount(cnt4));

    typedef struct {
        logic        rst;
        logic        valid;
        logic [4:0]  col;
        logic [4:0]  idx;
        logic [19:0] exp_strobe;
        logic        exp_ready;
        logic        exp_busy;
        logic        exp_err;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic write1(input logic [4:0] col, input logic [4:0] idx);
        @(negedge clk);
        valid1 = 1'b1;
        addr1  = {col, idx};
        @(negedge clk);
        valid1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        // rst, valid, col, idx, strobe, ready, busy, err, count
        vecs.push_back('{1'b1, 1'b0, 5'd0, 5'd0,  20'h00000, 1'b1, 1'b0, 1'b0, 16'd0});
        vecs.push_back('{1'b0, 1'b1, 5'd3, 5'd7,  20'h00000, 1'b0, 1'b1, 1'b0, 16'd0});
        vecs.push_back('{1'b0, 1'b0, 5'd3, 5'd7,  20'h00080, 1'b0, 1'b1, 1'b0, 16'd0});
        vecs.push_back('{1'b0, 1'b0, 5'd3, 5'd7,  20'h00000, 1'b0, 1'b1, 1'b0, 16'd1});
        vecs.push_back('{1'b0, 1'b0, 5'd3, 5'd7,  20'h00000, 1'b1, 1'b0, 1'b0, 16'd1});
        vecs.push_back('{1'b0, 1'b1, 5'd5, 5'd2,  20'h00000, 1'b1, 1'b0, 1'b0, 16'd1});
        vecs.push_back('{1'b0, 1'b0, 5'd5, 5'd2,  20'h00000, 1'b1, 1'b0, 1'b0, 16'd1});
        vecs.push_back('{1'b0, 1'b1, 5'd3, 5'd25, 20'h00000, 1'b1, 1'b0, 1'b1, 16'd1});
        vecs.push_back('{1'b0, 1'b1, 5'd3, 5'd0,  20'h00000, 1'b0, 1'b1, 1'b1, 16'd1});
        vecs.push_back('{1'b0, 1'b1, 5'd3, 5'd0,  20'h00001, 1'b0, 1'b1, 1'b1, 16'd1});
        vecs.push_back('{1'b0, 1'b1, 5'd3, 5'd0,  20'h00000, 1'b0, 1'b1, 1'b1, 16'd2});
        vecs.push_back('{1'b0, 1'b0, 5'd3, 5'd0,  20'h00000, 1'b1, 1'b0, 1'b1, 16'd2});
        vecs.push_back('{1'b0, 1'b1, 5'd0, 5'd4,  20'h00000, 1'b1, 1'b0, 1'b1, 16'd2});
        vecs.push_back('{1'b1, 1'b1, 5'd3, 5'd4,  20'h00000, 1'b1, 1'b0, 1'b0, 16'd0});
        vecs.push_back('{1'b0, 1'b0, 5'd3, 5'd4,  20'h00000, 1'b1, 1'b0, 1'b0, 16'd0});

        repeat (2) @(posedge clk);
        foreach (vecs[k]) begin
            @(negedge clk);
            rst1   = vecs[k].rst;
            valid1 = vecs[k].valid;
            addr1  = {vecs[k].col, vecs[k].idx};
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_strobe", k), 32'(strobe1), 32'(vecs[k].exp_strobe));
            chk($sformatf("v%0d_ready",  k), 32'(ready1),  32'(vecs[k].exp_ready));
            chk($sformatf("v%0d_busy",   k), 32'(busy1),   32'(vecs[k].exp_busy));
            chk($sformatf("v%0d_err",    k), 32'(err1),    32'(vecs[k].exp_err));
            chk($sformatf("v%0d_count",  k), 32'(cnt1),    32'(vecs[k].exp_cnt));
        end
        @(negedge clk);
        valid1 = 1'b0;

        // Back-to-back requests with valid held high; c is the observed cycle
        rst4  = 1'b0;
        addr4 = {5'd3, 5'd19};
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            valid4 = (c <= 8);
            @(posedge clk);
            #1;
            chk($sformatf("b2b_c%0d_strobe", c), 32'(strobe4),
                ((c >= 2 && c <= 5) || (c >= 9 && c <= 12)) ? 32'h0008_0000 : 32'h0);
            chk($sformatf("b2b_c%0d_ready", c), 32'(ready4),
                (c == 7 || c == 14) ? 32'd1 : 32'd0);
            chk($sformatf("b2b_c%0d_count", c), 32'(cnt4),
                32'((c >= 6) ? 1 : 0) + 32'((c >= 13) ? 1 : 0));
        end

        // Reset during the third cycle of a 4-cycle strobe
        @(negedge clk);
        rst4 = 1'b1;
        @(negedge clk);
        rst4   = 1'b0;
        valid4 = 1'b1;
        addr4  = {5'd3, 5'd19};
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            valid4 = 1'b0;
            rst4   = (c == 3);
            @(posedge clk);
            #1;
            chk($sformatf("rst_c%0d_strobe", c + 1), 32'(strobe4),
                (c + 1 == 2 || c + 1 == 3) ? 32'h0008_0000 : 32'h0);
            chk($sformatf("rst_c%0d_ready", c + 1), 32'(ready4),
                (c + 1 >= 4) ? 32'd1 : 32'd0);
            chk($sformatf("rst_c%0d_count", c + 1), 32'(cnt4), 32'd0);
        end
        chk("rst_err", 32'(err4), 32'd0);

        // Saturation: preload the count just below the ceiling
        @(negedge clk);
        force dut1.count_q = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut1.count_q;
        #1;
        chk("sat_preload", 32'(cnt1), 32'h0000_FFFE);
        write1(5'd3, 5'd1);
        chk("sat_first", 32'(cnt1), 32'h0000_FFFF);
        chk("sat_first_ready", 32'(ready1), 32'd1);
        write1(5'd3, 5'd2);
        chk("sat_second", 32'(cnt1), 32'h0000_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
